mem_requester: RTL

- Initiator-side controller for the fixed-latency main memory model; sits between a client (cache/CPU stub) and the memory's addr/we/data_in/data_out pins.
- Accepts one request at a time on a valid/ready handshake, drives the memory pins, and waits out the memory delay.
- Captures the memory's read data and returns it on a valid/ready response channel.
- Guarantees an address change at every issue, because the memory restarts its delay count only when its address changes.

---
 rtl/mem_requester_if.sv | 36 +++
 rtl/mem_requester.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_requester_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_requester_if
// Purpose  : Client request/response channels plus memory pins for mem_requester.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_requester_if #(
    parameter int ADDR_LENGTH = 10,
    parameter int WIDTH       = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_LENGTH-1:0] req_addr;
    logic [WIDTH-1:0]       req_wdata;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [WIDTH-1:0]       resp_rdata;
    logic [ADDR_LENGTH-1:0] mem_addr;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_wdata;
    logic [WIDTH-1:0]       mem_rdata;

    // Client and memory side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_addr, mem_we, mem_wdata
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_requester.sv
`default_nettype none
// ============================================================================
// Module   : mem_requester
// Purpose  : One-at-a-time initiator for a fixed-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_requester #(
    parameter int   LENGTH      = 1024,
    parameter int   WIDTH       = 8,
    parameter int   DELAY       = 50,
    localparam int  ADDR_LENGTH = $clog2(LENGTH)
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_requester_if.slave bus
);
    localparam int                     c_CNT_W    = $clog2(DELAY + 1);
    localparam logic [c_CNT_W-1:0]     c_CNT_LAST = c_CNT_W'(DELAY - 1);
    localparam logic [c_CNT_W-1:0]     c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [ADDR_LENGTH-1:0] c_BIT0     = ADDR_LENGTH'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUMP = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_lat_we;
    logic [ADDR_LENGTH-1:0] r_lat_addr;
    logic [WIDTH-1:0]       r_lat_wdata;
    logic [ADDR_LENGTH-1:0] r_mem_addr;
    logic                   r_mem_we;
    logic [WIDTH-1:0]       r_mem_wdata;
    logic                   r_resp_valid;
    logic [WIDTH-1:0]       r_resp_rdata;
    logic                   w_addr_same;

    // The memory restarts its latency only on an address change, so a repeat
    // address must first be bumped to a neighbour for one cycle.
    assign w_addr_same = (bus.req_addr == r_mem_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_lat_we     <= 1'b0;
            r_lat_addr   <= '0;
            r_lat_wdata  <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        if (w_addr_same) begin
                            r_mem_addr  <= bus.req_addr ^ c_BIT0;
                            r_mem_we    <= 1'b0;
                            r_lat_we    <= bus.req_we;
                            r_lat_addr  <= bus.req_addr;
                            r_lat_wdata <= bus.req_wdata;
                            r_state     <= c_BUMP;
                        end else begin
                            r_mem_addr  <= bus.req_addr;
                            r_mem_we    <= bus.req_we;
                            r_mem_wdata <= bus.req_wdata;
                            r_cnt       <= '0;
                            r_state     <= c_WAIT;
                        end
                    end
                end
                c_BUMP: begin
                    r_mem_addr  <= r_lat_addr;
                    r_mem_we    <= r_lat_we;
                    r_mem_wdata <= r_lat_wdata;
                    r_cnt       <= '0;
                    r_state     <= c_WAIT;
                end
                c_WAIT: begin
                    // Capture coincides with the write commit, so writes return the old word
                    if (r_cnt == c_CNT_LAST) begin
                        r_resp_rdata <= bus.mem_rdata;
                        r_resp_valid <= 1'b1;
                        r_mem_we     <= 1'b0;
                        r_state      <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == c_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire
